// File: rtl/countern_prog.sv
// countern_prog: programmable modulus/step counter with load, synchronous clear,
// wrap or saturate behaviour, and a carry output for cascading digit counters.
module countern_prog #(
  parameter int               WIDTH     = 8,
  parameter int               STEP_W    = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              load,
  input  logic [WIDTH-1:0]  load_val,
  input  logic              en,
  input  logic              count_up,
  input  logic              sat_mode,
  input  logic [WIDTH-1:0]  limit,
  input  logic [STEP_W-1:0] step,
  output logic [WIDTH-1:0]  counter,
  output logic              count_end,
  output logic              carry_out,
  output logic              wrapped
);

  // One extra bit over the wider operand so limit+1 and counter+step never overflow.
  localparam int AW = ((STEP_W > WIDTH) ? STEP_W : WIDTH) + 1;

  logic [WIDTH-1:0] counter_q, counter_d;
  logic             wrapped_q, wrapped_d;

  logic [AW-1:0] cnt_x, lim_x, mod_x, step_x, s_x, sum_x, next_x;
  logic          step_zero, out_of_range, up_cross, down_cross, count_end_c, carry_c;

  // Widen operands, clamp the step to the modulus and detect bound crossings.
  always_comb begin
    cnt_x        = AW'(counter_q);
    lim_x        = AW'(limit);
    mod_x        = lim_x + AW'(1);
    step_x       = AW'(step);
    s_x          = (step_x > mod_x) ? mod_x : step_x;
    sum_x        = cnt_x + s_x;
    step_zero    = (step == '0);
    out_of_range = (cnt_x > lim_x);
    up_cross     = (sum_x > lim_x);
    down_cross   = (cnt_x < s_x);
    // A zero step never moves the counter, so it never reports an end.
    count_end_c  = !step_zero && (out_of_range || (count_up ? up_cross : down_cross));
    carry_c      = en && count_end_c && !sat_mode && !clr && !load;
  end

  // Value the counter would take if an enabled step happened this cycle.
  always_comb begin
    next_x = cnt_x;
    if (step_zero) begin
      next_x = cnt_x;
    end else if (out_of_range) begin
      // An out-of-range value re-enters at the bound it would have crossed.
      next_x = count_up ? '0 : lim_x;
    end else if (count_up) begin
      if (!up_cross) next_x = sum_x;
      else           next_x = sat_mode ? lim_x : (sum_x - mod_x);
    end else begin
      if (!down_cross) next_x = cnt_x - s_x;
      else             next_x = sat_mode ? '0 : (cnt_x + mod_x - s_x);
    end
  end

  // Apply the per-edge priority clr > load > en; wrapped only follows a wrapping step.
  always_comb begin
    counter_d = counter_q;
    if (clr)       counter_d = '0;
    else if (load) counter_d = load_val;
    else if (en)   counter_d = WIDTH'(next_x);
    wrapped_d = carry_c;
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      counter_q <= RESET_VAL;
      wrapped_q <= 1'b0;
    end else begin
      counter_q <= counter_d;
      wrapped_q <= wrapped_d;
    end
  end

  assign counter   = counter_q;
  assign wrapped   = wrapped_q;
  assign count_end = count_end_c;
  assign carry_out = carry_c;

endmodule

// File: tb/tb_countern_prog.sv
// tb_countern_prog: scoreboard bench for countern_prog, including a two-digit cascade.
module tb_countern_prog;

  localparam int RV = 0;

  logic       clk = 1'b0;
  logic       rst_n, clr, load, en, count_up, sat_mode;
  logic [7:0] load_val, limit;
  logic [3:0] step;
  logic [7:0] counter;
  logic       count_end, carry_out, wrapped;

  logic       clr1;
  logic [7:0] limit1 = 8'd4;
  logic [7:0] counter1;
  logic       count_end1, carry_out1, wrapped1;

  always #5 clk = ~clk;

  countern_prog #(.WIDTH(8), .STEP_W(4), .RESET_VAL(8'(RV))) u_d0 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .load(load), .load_val(load_val),
    .en(en), .count_up(count_up), .sat_mode(sat_mode), .limit(limit), .step(step),
    .counter(counter), .count_end(count_end), .carry_out(carry_out), .wrapped(wrapped)
  );

  countern_prog #(.WIDTH(8), .STEP_W(4), .RESET_VAL(8'(RV))) u_d1 (
    .clk(clk), .rst_n(rst_n), .clr(clr1), .load(1'b0), .load_val(8'd0),
    .en(carry_out), .count_up(1'b1), .sat_mode(1'b0), .limit(limit1), .step(4'd1),
    .counter(counter1), .count_end(count_end1), .carry_out(carry_out1), .wrapped(wrapped1)
  );

  typedef struct {
    int ph; int cnt; bit ce; bit co; bit wr; int cnt1; bit co1; bit wr1;
  } rec_t;

  rec_t sb[$];
  int   n_checks = 0, n_pass = 0, txn = 0, phase = 0;
  int   m_cnt = RV, m1_cnt = RV;
  bit   m_wr = 0, m1_wr = 0;
  int   obs_ce[10], obs_co[10], obs_wr[10], obs_co1[10];

  function automatic void chk(input string nm, input int act, input int req);
    n_checks++;
    if (act == req) n_pass++;
    else $display("FAIL %s actual=%0d required=%0d (txn %0d)", nm, act, req, txn);
  endfunction

  // Reference behaviour: modulus arithmetic on plain integers.
  function automatic void model(input int c, input int lim, input int stp,
                                input bit up, input bit sat, input bit e,
                                input bit cl, input bit ld, input int ldv,
                                output int nxt, output bit ce, output bit co);
    int m, s;
    m = lim + 1;
    s = (stp > m) ? m : stp;
    if (stp == 0)     ce = 0;
    else if (c > lim) ce = 1;
    else if (up)      ce = (c + s > lim);
    else              ce = (c < s);
    co = e && ce && !sat && !cl && !ld;
    if (cl)                      nxt = 0;
    else if (ld)                 nxt = ldv;
    else if (!e || stp == 0)     nxt = c;
    else if (c > lim)            nxt = up ? 0 : lim;
    else if (up)                 nxt = sat ? ((c + s > lim) ? lim : c + s) : (c + s) % m;
    else                         nxt = sat ? ((c - s < 0) ? 0 : c - s) : (c - s + m) % m;
  endfunction

  // Push this cycle's expectation, then advance the model across the next edge.
  task automatic tick(input bit in_reset);
    rec_t r;
    int nxt, nxt1;
    bit ce, co, ce1, co1;
    model(m_cnt, int'(limit), int'(step), count_up, sat_mode, en, clr, load,
          int'(load_val), nxt, ce, co);
    model(m1_cnt, int'(limit1), 1, 1'b1, 1'b0, co, clr1, 1'b0, 0, nxt1, ce1, co1);
    r.ph = phase; r.cnt = m_cnt; r.ce = ce; r.co = co; r.wr = m_wr;
    r.cnt1 = m1_cnt; r.co1 = co1; r.wr1 = m1_wr;
    sb.push_back(r);
    if (!in_reset) begin
      m_cnt = nxt; m_wr = co; m1_cnt = nxt1; m1_wr = co1;
    end
    @(posedge clk); #1;
  endtask

  task automatic cyc(input bit cl, input bit ld, input int ldv, input bit e,
                     input bit up, input bit sat, input int lim, input int stp);
    clr = cl; load = ld; load_val = 8'(ldv); en = e;
    count_up = up; sat_mode = sat; limit = 8'(lim); step = 4'(stp);
    tick(1'b0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    m_cnt = RV; m_wr = 0; m1_cnt = RV; m1_wr = 0;
    tick(1'b1);
    rst_n = 1'b1;
  endtask

  // Monitor: one comparison set per presented cycle, decoupled from stimulus.
  initial begin
    rec_t r;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        r = sb.pop_front();
        txn++;
        $display("txn %0d ph=%0d counter=%0d ce=%0b co=%0b wr=%0b | digit1=%0d co1=%0b wr1=%0b",
                 txn, r.ph, counter, count_end, carry_out, wrapped, counter1, carry_out1, wrapped1);
        chk("counter",    int'(counter),   r.cnt);
        chk("count_end",  int'(count_end), int'(r.ce));
        chk("carry_out",  int'(carry_out), int'(r.co));
        chk("wrapped",    int'(wrapped),   int'(r.wr));
        chk("counter1",   int'(counter1),  r.cnt1);
        chk("carry_out1", int'(carry_out1), int'(r.co1));
        chk("wrapped1",   int'(wrapped1),  int'(r.wr1));
        if (count_end)  obs_ce[r.ph]++;
        if (carry_out)  obs_co[r.ph]++;
        if (wrapped)    obs_wr[r.ph]++;
        if (carry_out1) obs_co1[r.ph]++;
      end
    end
  end

  initial begin
    int lim, stp, ldv;
    bit cl, ld, e;
    rst_n = 1'b0; clr = 0; load = 0; load_val = 0; en = 0;
    count_up = 1; sat_mode = 0; limit = 8'd23; step = 4'd1; clr1 = 0;
    @(posedge clk); #1;

    // Reset state, mid-count reset, and clr/load/en together.
    phase = 1;
    do_reset();
    repeat (5) cyc(0, 0, 0, 1, 1, 0, 23, 1);
    do_reset();
    repeat (2) cyc(0, 0, 0, 1, 1, 0, 23, 1);
    cyc(1, 1, 7, 1, 1, 0, 23, 1);
    cyc(0, 0, 0, 0, 1, 0, 23, 1);

    // Legacy: limit 23, step 1, 24 enables.
    cyc(1, 0, 0, 0, 1, 0, 23, 1);
    phase = 2;
    repeat (24) cyc(0, 0, 0, 1, 1, 0, 23, 1);
    cyc(0, 0, 0, 0, 1, 0, 23, 1);

    // Stride wrap up from 20 and down from 3.
    phase = 3;
    cyc(0, 1, 20, 0, 1, 0, 24, 5);
    cyc(0, 0, 0, 1, 1, 0, 24, 5);
    cyc(0, 0, 0, 0, 1, 0, 24, 5);
    cyc(0, 1, 3, 0, 0, 0, 24, 5);
    cyc(0, 0, 0, 1, 0, 0, 24, 5);
    cyc(0, 0, 0, 0, 0, 0, 24, 5);

    // Saturate at limit 10 with step 4.
    phase = 4;
    cyc(0, 1, 8, 0, 1, 1, 10, 4);
    repeat (3) cyc(0, 0, 0, 1, 1, 1, 10, 4);
    cyc(0, 0, 0, 0, 1, 1, 10, 4);

    // Out-of-range load, then up and down recovery.
    phase = 5;
    cyc(0, 1, 200, 0, 1, 0, 9, 1);
    cyc(0, 0, 0, 0, 1, 0, 9, 1);
    cyc(0, 0, 0, 1, 1, 0, 9, 1);
    cyc(0, 1, 200, 0, 0, 0, 9, 1);
    cyc(0, 0, 0, 1, 0, 0, 9, 1);
    cyc(0, 0, 0, 0, 0, 0, 9, 1);

    // Cascade: two digits of modulus 5.
    clr1 = 1'b1;
    cyc(1, 0, 0, 0, 1, 0, 4, 1);
    clr1 = 1'b0;
    phase = 6;
    repeat (25) cyc(0, 0, 0, 1, 1, 0, 4, 1);
    cyc(0, 0, 0, 0, 1, 0, 4, 1);

    // limit = 0 in wrap and saturate modes.
    phase = 7;
    cyc(1, 0, 0, 0, 1, 0, 0, 3);
    repeat (3) cyc(0, 0, 0, 1, 1, 0, 0, 3);
    repeat (3) cyc(0, 0, 0, 1, 1, 1, 0, 3);
    repeat (2) cyc(0, 0, 0, 1, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0, 0, 1);

    // Randomised traffic.
    phase = 8;
    lim = 12;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 7) == 0)
        lim = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, 255));
      // Zero steps are only issued while the counter is inside the legal range.
      stp = (m_cnt > lim) ? int'($urandom_range(1, 15)) : int'($urandom_range(0, 15));
      cl  = ($urandom_range(0, 31) == 0);
      ld  = ($urandom_range(0, 15) == 0);
      ldv = int'($urandom_range(0, 255));
      e   = ($urandom_range(0, 3) != 0);
      cyc(cl, ld, ldv, e, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), lim, stp);
    end

    repeat (3) @(negedge clk);
    #1;
    chk("scoreboard_drained", sb.size(), 0);
    chk("legacy_count_end_once", obs_ce[2], 1);
    chk("legacy_wrap_once", obs_wr[2], 1);
    chk("stride_wraps", obs_wr[3], 2);
    chk("sat_no_wrap", obs_wr[4], 0);
    chk("sat_no_carry", obs_co[4], 0);
    chk("sat_count_end_seen", int'(obs_ce[4] >= 3), 1);
    chk("oor_count_end_seen", int'(obs_ce[5] >= 2), 1);
    chk("cascade_digit0_carries", obs_co[6], 5);
    chk("cascade_digit1_carry_once", obs_co1[6], 1);
    chk("limit0_wraps", obs_wr[7], 5);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
